// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the memory-access stage.
// funct3 encodings, FSM states and the alignment rule.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_t;

   // funct3[1:0] gives the access size; unknown codes are word accesses
   function automatic logic isMisaligned(
      input logic [2:0] funct3,
      input logic [1:0] addrLo
   );
      logic bad;
      unique case (funct3[1:0])
         2'b00:   bad = 1'b0;
         2'b01:   bad = addrLo[0];
         default: bad = |addrLo;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/memory_cycle_load_align.sv
// Load data extraction: picks the addressed byte/half
// from the read word and sign- or zero-extends it.
module load_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addrLo,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // lane selection from the low address bits
   always_comb begin
      byteSel = rdata[8*addrLo +: 8];
      halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
   end

   // extension by load type; anything unknown acts as LW
   always_comb begin
      unique case (funct3)
         F3_LB:   result = {{24{byteSel[7]}}, byteSel};
         F3_LH:   result = {{16{halfSel[15]}}, halfSel};
         F3_LBU:  result = {24'd0, byteSel};
         F3_LHU:  result = {16'd0, halfSel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/memory_cycle.sv
// M stage: data memory handshake, store lanes,
// load extraction and the MEM/WB register.
module memory_cycle
   import riscv_mem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          validM,
   input  logic          RegWriteM,
   input  logic          memtoRegM,
   input  logic          MemReadM,
   input  logic          MemWriteM,
   input  logic [DW-1:0] ALUOutM,
   input  logic [DW-1:0] WriteDataM,
   input  logic [DW-1:0] InstrM,
   output logic          stallM,
   output logic          misalignM,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [3:0]    dmem_be,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic          RegWriteW,
   output logic          memtoRegW,
   output logic [DW-1:0] ALUOutW,
   output logic [DW-1:0] InstrW,
   output logic [DW-1:0] readDataW
);

   mem_state_t state;
   mem_state_t nextState;

   logic [2:0]    funct3;
   logic [1:0]    addrLo;
   logic          memOp;
   logic          badAlign;
   logic          idleReq;
   logic          complete;
   logic          loadW;
   logic [3:0]    storeBe;
   logic [DW-1:0] storeData;
   logic [DW-1:0] loadData;

   assign funct3   = InstrM[14:12];
   assign addrLo   = ALUOutM[1:0];
   assign memOp    = validM & (MemReadM | MemWriteM);
   assign badAlign = isMisaligned(funct3, addrLo);
   assign idleReq  = memOp & ~badAlign;

   // state register; reset abandons any outstanding access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // handshake control, all forced low while in reset
   always_comb begin
      nextState = state;
      stallM    = 1'b0;
      dmem_req  = 1'b0;
      misalignM = 1'b0;
      if (rst) begin
         unique case (state)
            IDLE: begin
               misalignM = memOp & badAlign;
               dmem_req  = idleReq;
               stallM    = idleReq & ~dmem_ack;
               if (idleReq && !dmem_ack) nextState = WAIT;
            end
            WAIT: begin
               dmem_req = 1'b1;
               stallM   = ~dmem_ack;
               if (dmem_ack) nextState = IDLE;
            end
            default: nextState = IDLE;
         endcase
      end
   end

   // store byte enables and lane-replicated data
   always_comb begin
      storeBe   = 4'hF;
      storeData = WriteDataM;
      unique case (funct3[1:0])
         2'b00: begin
            storeBe   = 4'b0001 << addrLo;
            storeData = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            storeBe   = 4'b0011 << addrLo;
            storeData = {2{WriteDataM[15:0]}};
         end
         default: begin
            storeBe   = 4'hF;
            storeData = WriteDataM;
         end
      endcase
   end

   assign dmem_we    = dmem_req & MemWriteM;
   assign dmem_addr  = {ALUOutM[DW-1:2], 2'b00};
   assign dmem_be    = (validM & MemWriteM) ? storeBe : 4'b0000;
   assign dmem_wdata = storeData;

   load_align uAlign (
      .funct3 (funct3),
      .addrLo (addrLo),
      .rdata  (dmem_rdata),
      .result (loadData)
   );

   assign complete = dmem_req & dmem_ack;
   assign loadW    = validM & ~stallM & ~misalignM
                   & (~memOp | complete);

   // MEM/WB register: real instruction or a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW <= 1'b0;
         memtoRegW <= 1'b0;
         ALUOutW   <= '0;
         InstrW    <= '0;
         readDataW <= '0;
      end else if (loadW) begin
         RegWriteW <= RegWriteM;
         memtoRegW <= memtoRegM;
         ALUOutW   <= ALUOutM;
         InstrW    <= InstrM;
         readDataW <= memOp ? loadData : '0;
      end else begin
         RegWriteW <= 1'b0;
         memtoRegW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed table,
// randomized ops against a behavioural model, reset abort.
module tb_memory_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        validM, RegWriteM, memtoRegM, MemReadM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM, InstrM;
   logic        stallM, misalignM, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic        RegWriteW, memtoRegW;
   logic [31:0] ALUOutW, InstrW, readDataW;

   int nErr = 0;
   int nChk = 0;

   logic        eRw, eMtr;
   logic [31:0] eAlu, eIns, eRd;

   memory_cycle #(.DW(32)) dut (
      .clk(clk), .rst(rst), .validM(validM),
      .RegWriteM(RegWriteM), .memtoRegM(memtoRegM),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .InstrM(InstrM),
      .stallM(stallM), .misalignM(misalignM),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata),
      .RegWriteW(RegWriteW), .memtoRegW(memtoRegW),
      .ALUOutW(ALUOutW), .InstrW(InstrW), .readDataW(readDataW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit mMis(input logic [2:0] f3,
                               input logic [31:0] a);
      int sz;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      return (a % sz) != 0;
   endfunction

   function automatic logic [31:0] mExt(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] w);
      logic [31:0] s;
      case (f3)
         3'd0, 3'd4: begin
            s = (w >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'd0 && s >= 32'h80) s = s | 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            s = (w >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'd1 && s >= 32'h8000) s = s | 32'hFFFF_0000;
         end
         default: s = w;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] mBe(input logic [2:0] f3,
                                      input logic [31:0] a);
      if (f3 == 3'd0) return 4'(1 << a[1:0]);
      if (f3 == 3'd1) return 4'(3 << a[1:0]);
      return 4'hF;
   endfunction

   function automatic logic [31:0] mWd(input logic [2:0] f3,
                                       input logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   task automatic checkW(input string tag);
      chk({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, eRw});
      chk({tag, ".memtoRegW"}, {31'd0, memtoRegW}, {31'd0, eMtr});
      chk({tag, ".ALUOutW"}, ALUOutW, eAlu);
      chk({tag, ".InstrW"}, InstrW, eIns);
      chk({tag, ".readDataW"}, readDataW, eRd);
   endtask

   // one instruction through M; entered 1 time unit after a posedge
   task automatic runOp(
      input bit v, input bit rw, input bit mtr,
      input bit mr, input bit mw,
      input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] wd, input logic [31:0] rd,
      input int waits,
      output logic [3:0] capBe, output logic [31:0] capWd,
      output bit capMis, output int stallCnt
   );
      bit memOp, mis, req;
      int nCyc;
      logic [31:0] ins;
      ins = $urandom;
      ins[14:12] = f3;
      memOp = v && (mr || mw);
      mis = memOp && mMis(f3, addr);
      req = memOp && !mis;
      nCyc = req ? waits + 1 : 1;
      stallCnt = 0;
      capBe = 4'h0;
      capWd = 32'h0;
      capMis = 1'b0;
      for (int c = 0; c < nCyc; c++) begin
         validM = v; RegWriteM = rw; memtoRegM = mtr;
         MemReadM = mr; MemWriteM = mw;
         ALUOutM = addr; WriteDataM = wd; InstrM = ins;
         dmem_ack = req ? (c == waits) : 1'($urandom % 2);
         dmem_rdata = (req && c == waits) ? rd : $urandom;
         @(negedge clk);
         if (c == 0) begin
            capBe = dmem_be;
            capWd = dmem_wdata;
            capMis = misalignM;
         end
         if (stallM) stallCnt++;
         chk("stallM", {31'd0, stallM}, {31'd0, req && c < waits});
         chk("dmem_req", {31'd0, dmem_req}, {31'd0, req});
         chk("misalignM", {31'd0, misalignM}, {31'd0, mis});
         if (req) begin
            chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, mw});
            chk("dmem_be", {28'd0, dmem_be},
                {28'd0, mw ? mBe(f3, addr) : 4'h0});
            if (mw) chk("dmem_wdata", dmem_wdata, mWd(f3, wd));
         end
         @(posedge clk);
         #1;
         if (c == nCyc - 1 && v && !mis) begin
            eRw = rw; eMtr = mtr; eAlu = addr; eIns = ins;
            eRd = memOp ? mExt(f3, addr, rd) : 32'h0;
         end else begin
            eRw = 1'b0; eMtr = 1'b0;
         end
         checkW(c == nCyc - 1 ? "W" : "Wstall");
      end
   endtask

   typedef struct {
      string       nm;
      bit          rw, mr, mw;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rd;
      int          waits;
      logic [31:0] expRd;
      logic [3:0]  expBe;
      bit          chkWd;
      logic [31:0] expWd;
      bit          expMis;
      int          expStall;
   } vec_t;

   vec_t vt[12];

   initial begin
      logic [3:0]  be;
      logic [31:0] wdo;
      bit          mis;
      int          st;

      vt[0]  = '{"ADD",  1,0,0,3'd0,32'h1234,0,0,0,0,0,0,0,0,0};
      vt[1]  = '{"LB",   1,1,0,3'd0,32'h103,0,32'h80FF0000,0,
                 32'hFFFFFF80,0,0,0,0,0};
      vt[2]  = '{"LBU",  1,1,0,3'd4,32'h103,0,32'h80FF0000,0,
                 32'h80,0,0,0,0,0};
      vt[3]  = '{"SH",   0,0,1,3'd1,32'h202,32'hABCD1234,0,0,
                 0,4'b1100,1,32'h12341234,0,0};
      vt[4]  = '{"LWw3", 1,1,0,3'd2,32'h100,0,32'hDEADBEEF,3,
                 32'hDEADBEEF,0,0,0,0,3};
      vt[5]  = '{"LWmis",1,1,0,3'd2,32'h101,0,32'h1,0,0,0,0,0,1,0};
      vt[6]  = '{"LH",   1,1,0,3'd1,32'h102,0,32'h80017FFF,0,
                 32'hFFFF8001,0,0,0,0,0};
      vt[7]  = '{"LHU",  1,1,0,3'd5,32'h102,0,32'h80017FFF,1,
                 32'h8001,0,0,0,0,1};
      vt[8]  = '{"SB",   0,0,1,3'd0,32'h301,32'h55,0,0,
                 0,4'b0010,1,32'h55555555,0,0};
      vt[9]  = '{"SW",   0,0,1,3'd2,32'h400,32'hCAFEF00D,0,1,
                 0,4'hF,1,32'hCAFEF00D,0,1};
      vt[10] = '{"LHmis",1,1,0,3'd1,32'h103,0,0,0,0,0,0,0,1,0};
      vt[11] = '{"LF7",  1,1,0,3'd7,32'h10,0,32'h13579BDF,0,
                 32'h13579BDF,0,0,0,0,0};

      // reset state with a live aligned load on the inputs
      rst = 1'b0;
      validM = 1; RegWriteM = 1; memtoRegM = 1;
      MemReadM = 1; MemWriteM = 0;
      ALUOutM = 32'h40; WriteDataM = 0; InstrM = 32'h2000;
      dmem_ack = 0; dmem_rdata = 0;
      eRw = 0; eMtr = 0; eAlu = 0; eIns = 0; eRd = 0;
      #12;
      chk("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst.stallM", {31'd0, stallM}, 32'd0);
      chk("rst.misalignM", {31'd0, misalignM}, 32'd0);
      checkW("rst");
      validM = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vt[i]) begin
         runOp(1, vt[i].rw, vt[i].mr, vt[i].mr, vt[i].mw,
               vt[i].f3, vt[i].addr, vt[i].wd, vt[i].rd,
               vt[i].waits, be, wdo, mis, st);
         chk({vt[i].nm, ".be"}, {28'd0, be}, {28'd0, vt[i].expBe});
         if (vt[i].chkWd) chk({vt[i].nm, ".wdata"}, wdo, vt[i].expWd);
         chk({vt[i].nm, ".mis"}, {31'd0, mis}, {31'd0, vt[i].expMis});
         chk({vt[i].nm, ".stalls"}, st, vt[i].expStall);
         if (vt[i].mr && !vt[i].expMis)
            chk({vt[i].nm, ".rd"}, readDataW, vt[i].expRd);
         if (vt[i].nm == "ADD") chk("ADD.alu", ALUOutW, 32'h1234);
      end

      // late ack with nothing pending must be ignored
      validM = 0; dmem_ack = 1;
      @(negedge clk);
      chk("lateAck.stallM", {31'd0, stallM}, 32'd0);
      chk("lateAck.req", {31'd0, dmem_req}, 32'd0);
      @(posedge clk);
      #1;
      eRw = 0; eMtr = 0;
      checkW("lateAck");

      // reset while waiting aborts the access
      validM = 1; RegWriteM = 1; memtoRegM = 1;
      MemReadM = 1; MemWriteM = 0;
      ALUOutM = 32'h80; InstrM = 32'h2003; dmem_ack = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("abort.stallPre", {31'd0, stallM}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort.req", {31'd0, dmem_req}, 32'd0);
      chk("abort.stallM", {31'd0, stallM}, 32'd0);
      eRw = 0; eMtr = 0; eAlu = 0; eIns = 0; eRd = 0;
      checkW("abort");
      validM = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      dmem_ack = 1;
      @(negedge clk);
      chk("noReplay.req", {31'd0, dmem_req}, 32'd0);
      chk("noReplay.stallM", {31'd0, stallM}, 32'd0);
      @(posedge clk);
      #1;
      checkW("noReplay");

      // randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         int k;
         bit v, mr, mw;
         logic [2:0]  f3;
         logic [31:0] a;
         k = $urandom % 4;
         v = (k != 3);
         mr = (k == 1) || (k == 3 && $urandom % 2 == 1);
         mw = (k == 2);
         f3 = mw ? 3'($urandom % 3) : 3'($urandom % 8);
         a = $urandom;
         runOp(v, 1'($urandom % 2), 1'($urandom % 2), mr, mw,
               f3, a, $urandom, $urandom, $urandom % 4,
               be, wdo, mis, st);
      end

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end

endmodule
